// File: rtl/issue_controller.sv
// Issue controller between decode and the execute units: scoreboard-based hazard
// detection, in-flight limiting, control-flow wait and IF/ID hold/flush generation.
module issue_controller #(
  parameter int UNIT_W       = 3,
  parameter int ERR_UNIT     = 0,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [UNIT_W-1:0] dec_ex_unit,
  input  logic              dec_stall,
  input  logic              dec_rs1_en,
  input  logic              dec_rs2_en,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_rd_en,
  input  logic [4:0]        dec_rd,
  input  logic              issue_ready,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic              ex_done,
  input  logic              cf_done,
  input  logic              cf_taken,
  output logic              issue_valid,
  output logic              id_hold,
  output logic              id_flush,
  output logic              illegal_inst,
  output logic [31:0]       busy
);

  localparam int                CNT_W    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [UNIT_W-1:0] ERR_CODE = UNIT_W'(ERR_UNIT);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    CF_WAIT = 1'b1
  } state_t;

  state_t           state_r;
  logic [31:0]      busy_r;
  logic [31:0]      busy_nxt_s;
  logic [CNT_W-1:0] inflight_r;
  logic [CNT_W-1:0] inflight_nxt_s;
  logic             run_s;
  logic             hazard_s;
  logic             full_s;
  logic             issue_s;
  logic             fire_s;
  logic             illegal_s;
  logic             hold_s;
  logic             flush_s;

  // A register reference is a hazard only if it is pending and not being written back
  // this very cycle (the register file is write-first).
  function automatic logic reg_hazard(input logic        en,
                                      input logic [4:0]  idx,
                                      input logic [31:0] sb,
                                      input logic        wb_v,
                                      input logic [4:0]  wb_idx);
    return en && (idx != 5'd0) && sb[idx] && !(wb_v && (wb_idx == idx));
  endfunction

  // Issue decision, hold/flush generation; everything is forced low while reset is held.
  always_comb begin
    run_s    = (state_r == RUN);
    hazard_s = reg_hazard(dec_rs1_en, dec_rs1, busy_r, wb_en, wb_rd) ||
               reg_hazard(dec_rs2_en, dec_rs2, busy_r, wb_en, wb_rd) ||
               reg_hazard(dec_rd_en,  dec_rd,  busy_r, wb_en, wb_rd);
    full_s    = (inflight_r == MAX_CNT) && !ex_done;
    illegal_s = !rst && dec_valid && run_s && (dec_ex_unit == ERR_CODE);
    issue_s   = !rst && dec_valid && run_s && (dec_ex_unit != ERR_CODE) && !hazard_s && !full_s;
    fire_s    = issue_s && issue_ready;
    flush_s   = !rst && !run_s && cf_done && cf_taken;
    if (rst) begin
      hold_s = 1'b0;
    end else if (run_s) begin
      hold_s = dec_valid && !fire_s && !illegal_s;
    end else begin
      hold_s = !cf_done;
    end
  end

  // Next scoreboard: clear on writeback, then set on issue so a same-index set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wb_en) begin
      busy_nxt_s[wb_rd] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (fire_s && dec_rd_en && (dec_rd != 5'd0)) begin
      busy_nxt_s[dec_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Next in-flight count; completion with nothing outstanding saturates at zero.
  always_comb begin
    if (fire_s && !ex_done) begin
      inflight_nxt_s = inflight_r + CNT_W'(1);
    end else if (!fire_s && ex_done && (inflight_r != '0)) begin
      inflight_nxt_s = inflight_r - CNT_W'(1);
    end else begin
      inflight_nxt_s = inflight_r;
    end
  end

  // Tracking state: scoreboard and in-flight counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= 32'h0000_0000;
      inflight_r <= '0;
    end else begin
      busy_r     <= busy_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  // Control-flow FSM: park in CF_WAIT from a control-flow issue until it resolves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (fire_s && dec_stall) begin
            state_r <= CF_WAIT;
          end else begin
            state_r <= RUN;
          end
        end
        CF_WAIT: begin
          if (cf_done) begin
            state_r <= RUN;
          end else begin
            state_r <= CF_WAIT;
          end
        end
        default: state_r <= RUN;
      endcase
    end
  end

  assign issue_valid  = issue_s;
  assign id_hold      = hold_s;
  assign id_flush     = flush_s;
  assign illegal_inst = illegal_s;
  assign busy         = busy_r;

endmodule

// File: doc/issue_controller.md
Name: issue_controller

Overview:
- Sits between the decoder and the execute units (ALU, forwarder, jump, branch, mem).
- Decides each cycle whether the decoded instruction issues.
- Tracks in-flight destination registers with a scoreboard and holds fetch/decode while a jump or branch is unresolved.
- Drives the IF/ID hold and flush controls.

Parameters:
- UNIT_W, 3, width of the ex_unit code from the decoder.
- ERR_UNIT, 0, ex_unit code meaning illegal/undecodable instruction.
- MAX_INFLIGHT, 4, maximum issued-but-not-completed instructions (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- dec_valid  in  1  ID stage holds a decoded instruction.
- dec_ex_unit  in  UNIT_W  target execute unit.
- dec_stall  in  1  instruction is a control-flow op (jal/jalr/branch).
- dec_rs1_en, dec_rs2_en  in  1 each  source operand used.
- dec_rs1, dec_rs2  in  5 each  source register indices.
- dec_rd_en  in  1  destination written.
- dec_rd  in  5  destination index.
- issue_ready  in  1  target execute unit accepts this cycle.
- wb_en  in  1  register-file writeback this cycle.
- wb_rd  in  5  writeback index.
- ex_done  in  1  one instruction completed (any unit, incl. store/branch).
- cf_done  in  1  control-flow op resolved.
- cf_taken  in  1  redirect taken (valid with cf_done).
- issue_valid  out  1  instruction issues (with issue_ready = fire).
- id_hold  out  1  freeze PC and IF/ID register.
- id_flush  out  1  squash IF/ID contents.
- illegal_inst  out  1  pulse: dec_valid with ERR_UNIT.
- busy  out  32  scoreboard (debug/visibility).

Behaviour:
- State machine has two states, RUN and CF_WAIT. Reset state: RUN, busy=0, inflight=0. Reset mid-operation discards all tracking immediately.
- Operand hazard exists when, for a source with its _en set, index != 0 and busy[index]=1, unless wb_en=1 and wb_rd==index in the same cycle (register file is write-first, so that source is not a hazard).
- WAW hazard: dec_rd_en, dec_rd != 0, busy[dec_rd]=1 and not cleared by same-cycle wb.
- full = (inflight == MAX_INFLIGHT) and not ex_done this cycle.
- issue_valid (combinational) = dec_valid & state==RUN & dec_ex_unit!=ERR_UNIT & !hazard & !full.
- fire = issue_valid & issue_ready.
- illegal_inst = dec_valid & state==RUN & dec_ex_unit==ERR_UNIT. The instruction is dropped (not held), so id_hold=0 for it.
- id_hold in RUN = dec_valid & !fire & !illegal_inst. In CF_WAIT, id_hold=1 except in the cf_done cycle. All outputs are 0 during reset.
- id_flush = state==CF_WAIT & cf_done & cf_taken, for one cycle, same cycle as cf_done.
- Transitions:
  - RUN -> CF_WAIT on fire & dec_stall.
  - CF_WAIT -> RUN on cf_done.
  - cf_done in RUN is ignored.
- Scoreboard updates on the clock edge:
  - Clear busy[wb_rd] on wb_en.
  - Set busy[dec_rd] on fire & dec_rd_en & dec_rd != 0.
  - Same index cleared and set in one cycle: set wins.
  - busy[0] is always 0.
- Inflight counter: +1 on fire, -1 on ex_done. Both in one cycle: unchanged. ex_done at 0: stays 0 (no underflow).
- Issue latency: 0 cycles, since fire is same-cycle combinational. Scoreboard/counter effects are visible in the next cycle.

Test Plan:
- Reset, then dec_valid add rd=5, issue_ready=1 -> issue_valid=1 in the same cycle; next cycle busy=32'h20, inflight=1.
- busy[5]=1, then decode rs1=5 -> issue_valid=0, id_hold=1. Assert wb_en with wb_rd=5 in the same cycle -> issue_valid=1 (bypass). Next cycle busy[5]=0.
- Issue a branch (dec_stall=1) -> CF_WAIT, id_hold=1 while cf_done=0. cf_done=1, cf_taken=1 -> id_flush=1 for exactly one cycle, id_hold=0, state RUN. Repeat with cf_taken=0 -> id_flush stays 0.
- MAX_INFLIGHT=4: issue 4 instructions with no ex_done -> 5th sees issue_valid=0. Same cycle ex_done=1 -> 5th issues and inflight stays 4.
- dec_ex_unit=ERR_UNIT with dec_valid=1 -> illegal_inst=1, issue_valid=0, id_hold=0, scoreboard unchanged. Then rd=0 writes: busy stays 0.
- Assert rst while in CF_WAIT with busy=32'h0000_0F00 and inflight=3 -> immediately busy=0, all outputs 0. After release the state is RUN and a new instruction issues at once.
